// File: rtl/wb_trace_tx.sv
// Retire-trace serializer: queues {class, pc[, wd]} records from WB and streams them
// as bytes (0xA5, class, pc LE[, wd LE]). Define WB_TRACE_WD_EN to carry write-data.
module wb_trace_tx #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [5:0]  wb_opcode,
  input  logic [5:0]  wb_funct,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_wd,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_last,
  output logic        overflow,
  output logic [7:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
`ifdef WB_TRACE_WD_EN
  localparam int REC_W  = 72;
  localparam int BODY_N = 9;
`else
  localparam int REC_W  = 40;
  localparam int BODY_N = 5;
`endif
  localparam logic [3:0] LAST_IDX = 4'(BODY_N - 1);
  localparam logic [7:0] HDR_BYTE = 8'hA5;

  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  function automatic logic [7:0] classify(input logic [5:0] op, input logic [5:0] fn);
    logic [7:0] c;
    c = 8'h00;
    case (op)
      6'd0: begin
        case (fn)
          6'd32:   c = 8'h01;
          6'd34:   c = 8'h02;
          6'd36:   c = 8'h03;
          6'd37:   c = 8'h04;
          6'd0:    c = 8'h05;
          6'd42:   c = 8'h06;
          6'd27:   c = 8'h07;
          6'd16:   c = 8'h08;
          6'd18:   c = 8'h09;
          default: c = 8'h0F;
        endcase
      end
      6'd35:   c = 8'h10;
      6'd43:   c = 8'h11;
      6'd4:    c = 8'h12;
      6'd5:    c = 8'h13;
      6'd2:    c = 8'h14;
      6'd13:   c = 8'h15;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, rd_next;
  logic             empty, full, push, drop, pop, more;
  state_t           state, state_d;
  logic [3:0]       idx, idx_d;
  logic [REC_W-1:0] head;
  logic [7:0]       head_cls;
  logic [31:0]      head_pc;
  logic [7:0]       body_byte;
  logic             last_byte, accept;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Fullness is judged before the edge, so a same-edge pop never rescues a record.
  assign push     = wb_valid && !full;
  assign drop     = wb_valid && full;
  assign rd_next  = rd_ptr + {{AW{1'b0}}, 1'b1};
  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_cls = head[REC_W-1 -: 8];
  assign head_pc  = head[REC_W-9 -: 32];

  assign tx_valid  = (state != IDLE);
  assign last_byte = (state == BODY) && (idx == LAST_IDX);
  assign tx_last   = last_byte;
  assign accept    = tx_valid && tx_ready;
  assign pop       = accept && last_byte;
  // Another record is ready if entries remain after this pop or one lands this edge.
  assign more      = push || (rd_next != wr_ptr);

`ifdef WB_TRACE_WD_EN
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {classify(wb_opcode, wb_funct), wb_pc, wb_wd};
  end
`else
  logic unused_wd;
  assign unused_wd = ^wb_wd;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {classify(wb_opcode, wb_funct), wb_pc};
  end
`endif

  always_comb begin
    body_byte = 8'h00;
    case (idx)
      4'd0: body_byte = head_cls;
      4'd1: body_byte = head_pc[7:0];
      4'd2: body_byte = head_pc[15:8];
      4'd3: body_byte = head_pc[23:16];
      4'd4: body_byte = head_pc[31:24];
`ifdef WB_TRACE_WD_EN
      4'd5: body_byte = head[7:0];
      4'd6: body_byte = head[15:8];
      4'd7: body_byte = head[23:16];
      4'd8: body_byte = head[31:24];
`endif
      default: body_byte = 8'h00;
    endcase
  end

  always_comb begin
    tx_data = 8'h00;
    if (state == HDR)       tx_data = HDR_BYTE;
    else if (state == BODY) tx_data = body_byte;
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    case (state)
      IDLE: if (!empty) state_d = HDR;
      HDR: begin
        if (tx_ready) begin
          state_d = BODY;
          idx_d   = 4'd0;
        end
      end
      BODY: begin
        if (tx_ready) begin
          if (last_byte) begin
            state_d = more ? HDR : IDLE;
            idx_d   = 4'd0;
          end else begin
            idx_d = idx + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= 4'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      drop_cnt <= 8'h00;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_next;
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= sat_inc8(drop_cnt);
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_tx.sv
// Directed bench for wb_trace_tx: record format, stalls, overflow, reset, saturation.
// Record length follows WB_TRACE_WD_EN.
module tb_wb_trace_tx;

`ifdef WB_TRACE_WD_EN
  localparam int RLEN = 10;
`else
  localparam int RLEN = 6;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0;
  logic [5:0]  wb_opcode = '0;
  logic [5:0]  wb_funct = '0;
  logic [31:0] wb_pc = '0;
  logic [31:0] wb_wd = '0;
  logic        tx_ready = 1'b1;
  logic        tx_valid, tx_last, overflow;
  logic [7:0]  tx_data, drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_data [16];
  logic       rx_last [16];
  int         rx_n;

  wb_trace_tx #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_opcode(wb_opcode),
    .wb_funct(wb_funct), .wb_pc(wb_pc), .wb_wd(wb_wd), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic retire(input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] pc, input logic [31:0] wd);
    wb_valid = 1'b1; wb_opcode = op; wb_funct = fn; wb_pc = pc; wb_wd = wd;
    step();
    wb_valid = 1'b0;
  endtask

  // Gathers accepted bytes until one flagged last is taken or the budget runs out.
  task automatic collect(input int maxc);
    bit done;
    done = 0;
    rx_n = 0;
    for (int c = 0; c < maxc && !done; c++) begin
      if (tx_valid && tx_ready) begin
        if (rx_n < 16) begin
          rx_data[rx_n] = tx_data;
          rx_last[rx_n] = tx_last;
        end
        rx_n++;
        if (tx_last || rx_n >= 16) done = 1;
      end
      step();
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [7:0] cls,
                                          input logic [31:0] pc, input logic [31:0] wd);
    case (i)
      0: return 8'hA5;
      1: return cls;
      2: return pc[7:0];
      3: return pc[15:8];
      4: return pc[23:16];
      5: return pc[31:24];
      6: return wd[7:0];
      7: return wd[15:8];
      8: return wd[23:16];
      9: return wd[31:24];
      default: return 8'h00;
    endcase
  endfunction

  task automatic test_reset();
    repeat (3) step();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    checks++; if (tx_last !== 1'b0) begin errors++; $display("FAIL rst_tx_last got %b want 0", tx_last); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow); end
    checks++; if (drop_cnt !== 8'h00) begin errors++; $display("FAIL rst_drop_cnt got %h want 00", drop_cnt); end
    rst = 1'b1;
    repeat (2) step();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL idle_after_rst got %b want 0", tx_valid); end
  endtask

  task automatic test_alu_record();
    logic [7:0] exp [10] = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    tx_ready = 1'b1;
    retire(6'd0, 6'd32, 32'h0000_0010, 32'h1234_5678);
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL lat_edge_n got %b want 0", tx_valid); end
    step();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      errors++; $display("FAIL lat_edge_n1 got v=%b d=%h want v=1 d=a5", tx_valid, tx_data); end
    collect(40);
    checks++; if (rx_n !== RLEN) begin errors++; $display("FAIL alu_len got %0d want %0d", rx_n, RLEN); end
    for (int i = 0; i < RLEN && i < rx_n; i++) begin
      checks++; if (rx_data[i] !== exp[i] || rx_last[i] !== (i == RLEN - 1)) begin
        errors++; $display("FAIL alu_byte%0d got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp[i], i == RLEN - 1); end
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL alu_idle got %b want 0", tx_valid); end
  endtask

  task automatic test_jump();
    logic [7:0] exp [10] = '{8'hA5, 8'h14, 8'h20, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    retire(6'd2, 6'd0, 32'h0000_0020, 32'hDEAD_BEEF);
    collect(40);
    checks++; if (rx_n !== RLEN) begin errors++; $display("FAIL j_len got %0d want %0d", rx_n, RLEN); end
    for (int i = 0; i < RLEN && i < rx_n; i++) begin
      checks++; if (rx_data[i] !== exp[i] || rx_last[i] !== (i == RLEN - 1)) begin
        errors++; $display("FAIL j_byte%0d got %h/%b want %h/%b", i, rx_data[i], rx_last[i], exp[i], i == RLEN - 1); end
    end
  endtask

  task automatic test_stall();
    logic [3:0] pat;
    logic [7:0] hold_d;
    logic       hold_l;
    bit         stalled, done;
    int         n, nstall;
    pat = 4'b1001;
    stalled = 0; done = 0; n = 0; nstall = 0;
    retire(6'd35, 6'd0, 32'h0000_0004, 32'hCAFE_F00D);
    for (int c = 0; c < 120 && !done; c++) begin
      tx_ready = pat[c % 4];
      if (tx_valid) begin
        if (stalled) begin
          nstall++;
          checks++; if (tx_data !== hold_d || tx_last !== hold_l) begin
            errors++; $display("FAIL stall_hold got %h/%b want %h/%b", tx_data, tx_last, hold_d, hold_l); end
        end
        if (tx_ready) begin
          checks++; if (tx_data !== exp_byte(n, 8'h10, 32'h4, 32'hCAFE_F00D) || tx_last !== (n == RLEN - 1)) begin
            errors++; $display("FAIL stall_byte%0d got %h/%b want %h/%b", n, tx_data, tx_last,
                               exp_byte(n, 8'h10, 32'h4, 32'hCAFE_F00D), n == RLEN - 1); end
          if (tx_last) done = 1;
          n++;
          stalled = 0;
        end else begin
          stalled = 1; hold_d = tx_data; hold_l = tx_last;
        end
      end
      step();
    end
    tx_ready = 1'b1;
    checks++; if (n !== RLEN) begin errors++; $display("FAIL stall_len got %0d want %0d", n, RLEN); end
    checks++; if (nstall < 2) begin errors++; $display("FAIL stall_seen got %0d want >=2", nstall); end
  endtask

  task automatic test_classes();
    logic [5:0] ops [4] = '{6'd0, 6'd0, 6'd4, 6'd17};
    logic [5:0] fns [4] = '{6'd42, 6'd63, 6'd9, 6'd32};
    logic [7:0] cls [4] = '{8'h06, 8'h0F, 8'h12, 8'h00};
    tx_ready = 1'b0;
    for (int k = 0; k < 4; k++) retire(ops[k], fns[k], 32'h200 + 32'(k), 32'h0);
    tx_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      collect(40);
      checks++; if (rx_n !== RLEN || rx_data[1] !== cls[k] || rx_data[2] !== 8'(32'h200 + k)) begin
        errors++; $display("FAIL class%0d got n=%0d c=%h p=%h want n=%0d c=%h p=%h", k, rx_n, rx_data[1],
                           rx_data[2], RLEN, cls[k], 8'(32'h200 + k)); end
    end
  endtask

  task automatic test_overflow();
    tx_ready = 1'b0;
    for (int k = 0; k < 6; k++) retire(6'd0, 6'd34, 32'h100 + 32'(k * 4), 32'h1000 + 32'(k));
    checks++; if (overflow !== 1'b1 || drop_cnt !== 8'd2) begin
      errors++; $display("FAIL ovf_flags got o=%b c=%0d want o=1 c=2", overflow, drop_cnt); end
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      errors++; $display("FAIL ovf_wait got v=%b d=%h want v=1 d=a5", tx_valid, tx_data); end
    tx_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      collect(40);
      checks++; if (rx_n !== RLEN) begin errors++; $display("FAIL ovf_len%0d got %0d want %0d", r, rx_n, RLEN); end
      for (int i = 0; i < RLEN && i < rx_n; i++) begin
        checks++; if (rx_data[i] !== exp_byte(i, 8'h02, 32'h100 + 32'(r * 4), 32'h1000 + 32'(r))) begin
          errors++; $display("FAIL ovf_rec%0d_byte%0d got %h want %h", r, i, rx_data[i],
                             exp_byte(i, 8'h02, 32'h100 + 32'(r * 4), 32'h1000 + 32'(r))); end
      end
      if (r < 3) begin
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
          errors++; $display("FAIL ovf_b2b%0d got v=%b d=%h want v=1 d=a5", r, tx_valid, tx_data); end
      end else begin
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b want 0", tx_valid); end
      end
    end
  endtask

  task automatic test_reset_mid();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL rm_pre_ovf got %b want 1", overflow); end
    tx_ready = 1'b1;
    retire(6'd0, 6'd36, 32'h0000_0040, 32'h55);
    repeat (4) step();
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      errors++; $display("FAIL rm_mid got v=%b d=%h want v=1 d=00", tx_valid, tx_data); end
    #2 rst = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || tx_data !== 8'h00 || tx_last !== 1'b0) begin
      errors++; $display("FAIL rm_async got v=%b d=%h l=%b want 0/00/0", tx_valid, tx_data, tx_last); end
    checks++; if (overflow !== 1'b0 || drop_cnt !== 8'h00) begin
      errors++; $display("FAIL rm_flags got o=%b c=%h want 0/00", overflow, drop_cnt); end
    step();
    rst = 1'b1;
    repeat (2) step();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rm_abandon got %b want 0", tx_valid); end
    retire(6'd0, 6'd37, 32'h0000_0080, 32'h1122_3344);
    collect(40);
    checks++; if (rx_n !== RLEN) begin errors++; $display("FAIL rm_len got %0d want %0d", rx_n, RLEN); end
    for (int i = 0; i < RLEN && i < rx_n; i++) begin
      checks++; if (rx_data[i] !== exp_byte(i, 8'h04, 32'h80, 32'h1122_3344)) begin
        errors++; $display("FAIL rm_byte%0d got %h want %h", i, rx_data[i], exp_byte(i, 8'h04, 32'h80, 32'h1122_3344)); end
    end
  endtask

  task automatic test_saturate();
    tx_ready = 1'b0;
    wb_valid = 1'b1; wb_opcode = 6'd43; wb_funct = 6'd0; wb_wd = 32'h0;
    for (int k = 0; k < 304; k++) begin
      if (k == 5) begin
        checks++; if (drop_cnt !== 8'd1 || overflow !== 1'b1) begin
          errors++; $display("FAIL sat_first got c=%0d o=%b want c=1 o=1", drop_cnt, overflow); end
      end
      wb_pc = 32'(k);
      step();
    end
    wb_valid = 1'b0;
    checks++; if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin
      errors++; $display("FAIL sat_final got c=%0d o=%b want c=255 o=1", drop_cnt, overflow); end
    tx_ready = 1'b1;
    collect(40);
    checks++; if (rx_n !== RLEN || rx_data[1] !== 8'h11 || rx_data[2] !== 8'h00) begin
      errors++; $display("FAIL sat_rec got n=%0d c=%h p=%h want n=%0d c=11 p=00", rx_n, rx_data[1], rx_data[2], RLEN); end
  endtask

  initial begin
    test_reset();
    test_alu_record();
    test_jump();
    test_stall();
    test_classes();
    test_overflow();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
